// File: rtl/fifo_reader_pkg.sv
// Shared constants for the show-ahead FIFO pop-side reader and its 2-entry output buffer.
package fifo_reader_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned BURST_DEF = 4;
    localparam int unsigned CNT_W_DEF = 16;

    // Output buffer occupancy encoding
    localparam int unsigned OCC_W = 2;
    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    // Counter width for 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_reader_skid2.sv
// Two-entry registered buffer: head drives the stream, tail absorbs one word of backpressure.
module fifo_reader_skid2
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occ
);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Occupancy moves by in - accept; the producer never offers a word while full
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        accept = (occ_q != OCC_EMPTY) & out_ready;
        case (occ_q)
            OCC_EMPTY: begin
                if (in_valid) begin
                    head_d = in_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_valid && accept) begin
                    head_d = in_data;
                end else if (in_valid) begin
                    tail_d = in_data;
                    occ_d  = OCC_FULL;
                end else if (accept) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (accept) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_data  = head_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Pops a show-ahead FIFO into a 2-entry buffer and presents it as a valid/ready burst stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned BURST = BURST_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    localparam int unsigned BC_W = cnt_width(BURST);
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST - 1);

    logic [OCC_W-1:0] occ;
    logic             accept;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    // Pop decision uses only buffer state and FIFO/enable inputs, never out_ready
    assign fifo_pop = rst_n & en & ~fifo_empty & (occ != OCC_FULL);

    fifo_reader_skid2 #(
        .WIDTH(WIDTH)
    ) u_skid2 (
        .clk      (CLK),
        .rst_n    (rst_n),
        .in_valid (fifo_pop),
        .in_data  (fifo_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occ      (occ)
    );

    assign accept = out_valid & out_ready;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q   <= '0;
            word_count_q <= '0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        word_count_d = word_count_q;
        if (accept) begin
            beat_cnt_d   = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BC_W'(1);
            word_count_d = word_count_q + CNT_W'(1);
        end
    end

    assign out_last   = out_valid & (beat_cnt_q == BEAT_LAST);
    assign busy       = out_valid;
    assign word_count = word_count_q;

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
Consumer for the pop side of the team's 8-entry show-ahead FIFO. It pops words whenever downstream buffering allows and holds them in a 2-entry registered output buffer. It presents them as a valid/ready stream, with out_last marking every BURST-th accepted word. It sits between the FIFO and downstream stream sinks (serializers, packetizers) and has no combinational path from out_ready to fifo_pop.

Parameters:
WIDTH, 8, data word width (matches FIFO data_out)
BURST, 4, accepted beats per burst; out_last marks beat BURST-1; must be >= 1
CNT_W, 16, width of word_count

Ports:
CLK  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  enable for popping from the FIFO
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead)
fifo_pop  output  1  FIFO pop strobe; one word consumed per cycle high
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts the word
out_data  output  WIDTH  stream word
out_last  output  1  word is the final beat of a burst
busy  output  1  output buffer non-empty
word_count  output  CNT_W  total accepted beats, wraps modulo 2^CNT_W

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (rst_n). Every register clears on rst_n falling, with no clock needed.
- Reset values: occupancy=0, beat_cnt=0, word_count=0, buffer entries=0.
- Reset outputs: out_valid=0, out_data=0, out_last=0, busy=0, fifo_pop=0.
- fifo_pop = rst_n & en & ~fifo_empty & (occ != 2). It depends only on registered state and inputs, never on out_ready.
- Capture: on the clock edge where fifo_pop=1, fifo_data is written into the buffer.
  - If occ=0, or occ=1 and the head is drained that cycle, the word lands at the head.
  - Otherwise it lands in the tail.
- Latency: FIFO word to out_valid is 1 cycle.
- Throughput: with out_ready held high, the steady state is 1 word/cycle at occ=1.
- Drain: a beat is accepted when out_valid & out_ready. The head is removed and the tail shifts to the head.
- Occupancy update per cycle is occ + pop - accept. It stays within 0..2 by construction.
  - occ=2 with accept gives occ=1. There is no pop that cycle.
  - occ=1 with pop and accept gives occ=1, and the head is replaced by the new word.
  - occ=0 with accept is impossible, since out_valid=0.
- out_valid = busy = (occ != 0). out_data = head entry, registered.
- out_data must stay stable while out_valid=1 and out_ready=0. out_valid never drops without an accept.
- beat_cnt: counts 0..BURST-1, increments on accept, and wraps to 0 after BURST-1.
- out_last = out_valid & (beat_cnt == BURST-1). When BURST=1, out_last = out_valid.
- word_count increments on each accept and wraps from 2^CNT_W-1 to 0.
- en deasserted: popping stops immediately (combinationally). Words already buffered are still emitted. beat_cnt is not reset, so the burst resumes when en returns, with no padding.
- fifo_empty rising while occ>0: buffered words drain normally and out_last still follows beat_cnt.
- Reset mid-operation: buffered words are discarded and fifo_pop goes low immediately. The first accepted beat after reset has beat index 0.
- X on fifo_data while fifo_empty=1 must never reach out_data.

Decomposition:
- Shared package fifo_reader_pkg holds the default WIDTH/BURST/CNT_W constants and the occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- One sub-module, fifo_reader_skid2. It is the 2-entry buffer with in_valid/in_data and out_valid/out_ready/out_data, and exposes occ.
- The top level holds the pop logic, beat_cnt, out_last and word_count.

Test Plan:
- Basic flow: FIFO preloaded with 0x11,0x22,0x33,0x44, en=1, out_ready=1.
  - Expect 4 pops on consecutive cycles.
  - out_data = 0x11..0x44 on consecutive cycles, starting 1 cycle after the first pop.
  - out_last=1 only with 0x44; word_count=4.
- Backpressure: FIFO holds 0xA0..0xA5, out_ready=0 for 5 cycles, then 1.
  - Exactly 2 pops, then fifo_pop=0 and out_data=0xA0 stable.
  - After release, all 6 words arrive in order with no loss or duplication.
- Burst wrap: BURST=4, 10 words streamed.
  - out_last high on words 4 and 8 only.
  - After the stream, beat_cnt=2; the next word shows out_last=0.
- Enable gating: 8 words queued, en dropped after 3 pops.
  - fifo_pop goes low in the same cycle.
  - The 3 buffered words drain; busy goes 0; fifo_empty stays 0 with 5 words remaining.
- Async reset mid-burst: with occ=2 and beat_cnt=2, pulse rst_n low between clock edges.
  - out_valid, fifo_pop and out_last go 0 immediately; word_count=0.
  - The next burst's 4th accepted word carries out_last.
- Counter wrap: CNT_W=4, 17 words streamed; word_count reads 1 at the end.
